// File: rtl/psevdo_ram_pkg.sv
// Purpose : shared types, defaults and helpers for the psevdo_ram 2R1W storage primitive.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state type (ST_CLEAR sweep / ST_RUN service), default geometry
// localparams, and the even-parity helper used when PSEVDO_RAM_PARITY_EN is defined.
package psevdo_ram_pkg;

  localparam int DW_DEF    = 9;
  localparam int AW_DEF    = 8;
  localparam int DEPTH_DEF = 256;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // Even parity: the returned bit makes the total number of ones even.
  // Callers zero-extend their word to 32 bits, which leaves the result unchanged.
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/psevdo_ram_2r1w_if.sv
// Purpose : bundle of the write port, both read ports and READY for psevdo_ram_2r1w.
// Latency : n/a (wiring only).
// Backpressure: none; READY tells the master when requests are honoured.
//
// Signals: DIn/WADDR/WRB write port, RADDRx/RDBx read requests, DOx read data,
// READY clear-done flag, PERRx parity flags (only with PSEVDO_RAM_PARITY_EN).
// slave = RAM side, master = client side.
interface psevdo_ram_2r1w_if
  import psevdo_ram_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic [DW-1:0] DIn;
  logic [AW-1:0] WADDR;
  logic          WRB;
  logic [AW-1:0] RADDR1;
  logic [AW-1:0] RADDR2;
  logic          RDB1;
  logic          RDB2;
  logic [DW-1:0] DO1;
  logic [DW-1:0] DO2;
  logic          READY;
`ifdef PSEVDO_RAM_PARITY_EN
  logic          PERR1;
  logic          PERR2;
`endif

  modport slave (
    input  DIn, WADDR, WRB, RADDR1, RADDR2, RDB1, RDB2,
    output DO1, DO2, READY
`ifdef PSEVDO_RAM_PARITY_EN
    , PERR1, PERR2
`endif
  );

  modport master (
    output DIn, WADDR, WRB, RADDR1, RADDR2, RDB1, RDB2,
    input  DO1, DO2, READY
`ifdef PSEVDO_RAM_PARITY_EN
    , PERR1, PERR2
`endif
  );

endinterface

// File: rtl/psevdo_ram_rdport.sv
// Purpose : one registered read port of psevdo_ram_2r1w (range check, write bypass, pipeline).
// Latency : 1 + RD_PIPE clock edges from the edge that samples rdb=0.
// Backpressure: none; rdb=1 holds stage 1 so the output keeps its last value.
//
// Ports: clk/rst, run (array is in service), rdb/raddr read request, wrb/waddr/din
// snoop of the write port for the collision bypass, mem_rdat raw array word,
// do_dat read data, perr parity flag (only with PSEVDO_RAM_PARITY_EN).
module psevdo_ram_rdport
  import psevdo_ram_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int AW          = AW_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int RD_PIPE     = 0,
  parameter int WRITE_FIRST = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  input  logic          rdb,
  input  logic [AW-1:0] raddr,
  input  logic          wrb,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
`ifdef PSEVDO_RAM_PARITY_EN
  input  logic [DW:0]   mem_rdat,
  output logic          perr,
`else
  input  logic [DW-1:0] mem_rdat,
`endif
  output logic [DW-1:0] do_dat
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic addr_ok;
  logic hit_wr;

  // The extra top bit keeps DEPTH == 2**AW representable.
  assign addr_ok = ({1'b0, raddr} < DEPTH_L);
  // Same-cycle write to the word being read; only honoured in write-first mode.
  assign hit_wr  = (WRITE_FIRST != 0) && !wrb && (raddr == waddr);

  logic [DW-1:0] s1_dat_q, s1_dat_d;

  always_comb begin
    s1_dat_d = s1_dat_q;
    if (!run) begin
      s1_dat_d = '0;
    end else if (!rdb) begin
      if (!addr_ok)    s1_dat_d = '0;
      else if (hit_wr) s1_dat_d = din;
      else             s1_dat_d = mem_rdat[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) s1_dat_q <= '0;
    else     s1_dat_q <= s1_dat_d;
  end

`ifdef PSEVDO_RAM_PARITY_EN
  logic s1_perr_q, s1_perr_d;

  // The bypass word carries fresh parity of din, so it can never flag an error.
  always_comb begin
    s1_perr_d = s1_perr_q;
    if (!run) begin
      s1_perr_d = 1'b0;
    end else if (!rdb) begin
      if (!addr_ok || hit_wr) s1_perr_d = 1'b0;
      else s1_perr_d = (even_parity(32'(mem_rdat[DW-1:0])) != mem_rdat[DW]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) s1_perr_q <= 1'b0;
    else     s1_perr_q <= s1_perr_d;
  end
`endif

  generate
    if (RD_PIPE != 0) begin : g_pipe
      // Stage 2 follows stage 1 every cycle; holding stage 1 therefore holds the output.
      logic [DW-1:0] s2_dat_q, s2_dat_d;
      always_comb s2_dat_d = s1_dat_q;
      always_ff @(posedge clk) begin
        if (rst) s2_dat_q <= '0;
        else     s2_dat_q <= s2_dat_d;
      end
      assign do_dat = s2_dat_q;
`ifdef PSEVDO_RAM_PARITY_EN
      logic s2_perr_q, s2_perr_d;
      always_comb s2_perr_d = s1_perr_q;
      always_ff @(posedge clk) begin
        if (rst) s2_perr_q <= 1'b0;
        else     s2_perr_q <= s2_perr_d;
      end
      assign perr = s2_perr_q;
`endif
    end else begin : g_nopipe
      assign do_dat = s1_dat_q;
`ifdef PSEVDO_RAM_PARITY_EN
      assign perr = s1_perr_q;
`endif
    end
  endgenerate

endmodule

// File: rtl/psevdo_ram_2r1w.sv
// Purpose : DEPTH x DW single-clock RAM, one write + two read ports, hardware clear after reset.
// Latency : reads 1 + RD_PIPE edges; a write is visible to a read sampled one edge later.
// Backpressure: none; READY stays low during the DEPTH-cycle clear sweep, when requests are ignored.
//
// Ports: CLKS clock, RST synchronous active-high reset, bus (psevdo_ram_2r1w_if.slave)
// carrying DIn/WADDR/WRB, RADDR1/RDB1, RADDR2/RDB2, DO1/DO2, READY and, when the
// PSEVDO_RAM_PARITY_EN macro is defined, PERR1/PERR2 (array stores an even-parity bit).
module psevdo_ram_2r1w
  import psevdo_ram_pkg::*;
#(
  parameter int DW          = DW_DEF,
  parameter int AW          = AW_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int RD_PIPE     = 0,
  parameter int WRITE_FIRST = 1
) (
  input  logic             CLKS,
  input  logic             RST,
  psevdo_ram_2r1w_if.slave bus
);

`ifdef PSEVDO_RAM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif
  localparam logic [AW:0]   DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [MW-1:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          ready_q, ready_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [MW-1:0] mem_wdat;
  logic [MW-1:0] wr_word;
  logic          waddr_ok;
  logic          run;

`ifdef PSEVDO_RAM_PARITY_EN
  assign wr_word = {even_parity(32'(bus.DIn)), bus.DIn};
`else
  assign wr_word = bus.DIn;
`endif

  assign waddr_ok = ({1'b0, bus.WADDR} < DEPTH_L);
  assign run      = (state_q == ST_RUN);

  // Clear FSM and the single array write mux. The sweep owns the write port
  // while clearing; any write in a cycle with RST high is dropped.
  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    ready_d    = ready_q;
    mem_we     = 1'b0;
    mem_waddr  = bus.WADDR;
    mem_wdat   = wr_word;
    case (state_q)
      ST_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdat  = '0;
        if (clr_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
        end
      end
      ST_RUN: begin
        mem_we = !bus.WRB && waddr_ok;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
    if (RST) mem_we = 1'b0;
  end

  always_ff @(posedge CLKS) begin
    if (RST) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      ready_q    <= ready_d;
    end
  end

  // Array has no reset; the sweep provides the defined contents.
  always_ff @(posedge CLKS) begin
    if (mem_we) mem[mem_waddr] <= mem_wdat;
  end

  // Out-of-range reads are zeroed inside the port; index 0 just keeps the lookup in bounds.
  logic [AW-1:0] rd1_idx, rd2_idx;
  logic [MW-1:0] rd1_word, rd2_word;

  assign rd1_idx  = ({1'b0, bus.RADDR1} < DEPTH_L) ? bus.RADDR1 : '0;
  assign rd2_idx  = ({1'b0, bus.RADDR2} < DEPTH_L) ? bus.RADDR2 : '0;
  assign rd1_word = mem[rd1_idx];
  assign rd2_word = mem[rd2_idx];

  logic [DW-1:0] do1_dat, do2_dat;

  psevdo_ram_rdport #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_PIPE(RD_PIPE), .WRITE_FIRST(WRITE_FIRST)
  ) u_rd1 (
    .clk      (CLKS),
    .rst      (RST),
    .run      (run),
    .rdb      (bus.RDB1),
    .raddr    (bus.RADDR1),
    .wrb      (bus.WRB),
    .waddr    (bus.WADDR),
    .din      (bus.DIn),
    .mem_rdat (rd1_word),
`ifdef PSEVDO_RAM_PARITY_EN
    .perr     (bus.PERR1),
`endif
    .do_dat   (do1_dat)
  );

  psevdo_ram_rdport #(
    .DW(DW), .AW(AW), .DEPTH(DEPTH), .RD_PIPE(RD_PIPE), .WRITE_FIRST(WRITE_FIRST)
  ) u_rd2 (
    .clk      (CLKS),
    .rst      (RST),
    .run      (run),
    .rdb      (bus.RDB2),
    .raddr    (bus.RADDR2),
    .wrb      (bus.WRB),
    .waddr    (bus.WADDR),
    .din      (bus.DIn),
    .mem_rdat (rd2_word),
`ifdef PSEVDO_RAM_PARITY_EN
    .perr     (bus.PERR2),
`endif
    .do_dat   (do2_dat)
  );

  assign bus.DO1   = do1_dat;
  assign bus.DO2   = do2_dat;
  assign bus.READY = ready_q;

endmodule

// File: tb/tb_psevdo_ram_2r1w.sv
// Purpose : directed self-checking bench for psevdo_ram_2r1w.
// Latency : n/a.
// Backpressure: n/a.
//
// dut_a: defaults (DEPTH 256, RD_PIPE 0, write-first). dut_b: DEPTH 200, RD_PIPE 1,
// read-old. Both see identical stimulus; each has its own expected values.
module tb_psevdo_ram_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [8:0] din;
  logic [7:0] waddr, raddr1, raddr2;
  logic       wrb, rdb1, rdb2;

  int checks = 0;
  int errors = 0;

  psevdo_ram_2r1w_if #(.DW(9), .AW(8)) ifa ();
  psevdo_ram_2r1w_if #(.DW(9), .AW(8)) ifb ();

  assign ifa.DIn = din;    assign ifb.DIn = din;
  assign ifa.WADDR = waddr; assign ifb.WADDR = waddr;
  assign ifa.WRB = wrb;    assign ifb.WRB = wrb;
  assign ifa.RADDR1 = raddr1; assign ifb.RADDR1 = raddr1;
  assign ifa.RADDR2 = raddr2; assign ifb.RADDR2 = raddr2;
  assign ifa.RDB1 = rdb1;  assign ifb.RDB1 = rdb1;
  assign ifa.RDB2 = rdb2;  assign ifb.RDB2 = rdb2;

  psevdo_ram_2r1w #(.DW(9), .AW(8), .DEPTH(256), .RD_PIPE(0), .WRITE_FIRST(1))
    dut_a (.CLKS(clk), .RST(rst), .bus(ifa.slave));

  psevdo_ram_2r1w #(.DW(9), .AW(8), .DEPTH(200), .RD_PIPE(1), .WRITE_FIRST(0))
    dut_b (.CLKS(clk), .RST(rst), .bus(ifb.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [8:0] d);
    waddr = a; din = d; wrb = 1'b0;
    tick();
    wrb = 1'b1;
  endtask

  // Read sampled on one edge, then held; two edges cover both latencies.
  task automatic do_read(input logic [7:0] a1, input logic [7:0] a2);
    raddr1 = a1; raddr2 = a2; rdb1 = 1'b0; rdb2 = 1'b0;
    tick();
    rdb1 = 1'b1; rdb2 = 1'b1;
    tick();
  endtask

  // Releases reset and measures the edge count at which each READY first rises.
  task automatic wait_sweep(input string tag);
    int ra, rb;
    ra = 0; rb = 0;
    rst = 1'b0;
    for (int n = 1; n <= 300; n++) begin
      tick();
      if (ifa.READY === 1'b1 && ra == 0) ra = n;
      if (ifb.READY === 1'b1 && rb == 0) rb = n;
    end
    checks++; if (ra != 256) begin errors++; $display("FAIL %s_sweep_a: READY rose at edge %0d, want 256", tag, ra); end
    checks++; if (rb != 200) begin errors++; $display("FAIL %s_sweep_b: READY rose at edge %0d, want 200", tag, rb); end
  endtask

  task automatic test_reset();
    rst = 1'b1; din = '0; waddr = '0; wrb = 1'b1;
    raddr1 = '0; raddr2 = '0; rdb1 = 1'b1; rdb2 = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (ifa.READY !== 1'b0) begin errors++; $display("FAIL rst_ready_a: got %b want 0", ifa.READY); end
    checks++; if (ifa.DO1 !== 9'h000) begin errors++; $display("FAIL rst_do1_a: got %h want 000", ifa.DO1); end
    checks++; if (ifa.DO2 !== 9'h000) begin errors++; $display("FAIL rst_do2_a: got %h want 000", ifa.DO2); end
    checks++; if (ifb.READY !== 1'b0) begin errors++; $display("FAIL rst_ready_b: got %b want 0", ifb.READY); end
    checks++; if (ifb.DO1 !== 9'h000) begin errors++; $display("FAIL rst_do1_b: got %h want 000", ifb.DO1); end
    checks++; if (ifb.DO2 !== 9'h000) begin errors++; $display("FAIL rst_do2_b: got %h want 000", ifb.DO2); end
    wait_sweep("reset");
  endtask

  task automatic test_clear_reads();
    logic [7:0] addrs [3];
    addrs[0] = 8'd0; addrs[1] = 8'd128; addrs[2] = 8'd255;
    for (int i = 0; i < 3; i++) begin
      do_read(addrs[i], addrs[i]);
      checks++; if (ifa.DO1 !== 9'h000) begin errors++; $display("FAIL clr_do1_a[%0d]: got %h want 000", addrs[i], ifa.DO1); end
      checks++; if (ifa.DO2 !== 9'h000) begin errors++; $display("FAIL clr_do2_a[%0d]: got %h want 000", addrs[i], ifa.DO2); end
      checks++; if (ifb.DO1 !== 9'h000) begin errors++; $display("FAIL clr_do1_b[%0d]: got %h want 000", addrs[i], ifb.DO1); end
      checks++; if (ifb.DO2 !== 9'h000) begin errors++; $display("FAIL clr_do2_b[%0d]: got %h want 000", addrs[i], ifb.DO2); end
    end
  endtask

  task automatic test_dual_port();
    do_write(8'd3, 9'h1A5);
    do_write(8'd200, 9'h07E);   // out of range for dut_b: dropped
    raddr1 = 8'd3; raddr2 = 8'd200; rdb1 = 1'b0; rdb2 = 1'b0;
    tick();
    rdb1 = 1'b1; rdb2 = 1'b1;
    checks++; if (ifa.DO1 !== 9'h1A5) begin errors++; $display("FAIL dual_do1_a: got %h want 1a5", ifa.DO1); end
    checks++; if (ifa.DO2 !== 9'h07E) begin errors++; $display("FAIL dual_do2_a: got %h want 07e", ifa.DO2); end
    checks++; if (ifb.DO1 !== 9'h000) begin errors++; $display("FAIL dual_lat_b: got %h want 000 (data one edge early)", ifb.DO1); end
    tick();
    checks++; if (ifb.DO1 !== 9'h1A5) begin errors++; $display("FAIL dual_do1_b: got %h want 1a5", ifb.DO1); end
    checks++; if (ifb.DO2 !== 9'h000) begin errors++; $display("FAIL dual_do2_b: got %h want 000", ifb.DO2); end
  endtask

  task automatic test_collision();
    do_write(8'd10, 9'h055);
    waddr = 8'd10; din = 9'h1AA; wrb = 1'b0;
    raddr1 = 8'd10; raddr2 = 8'd10; rdb1 = 1'b0; rdb2 = 1'b0;
    tick();
    wrb = 1'b1; rdb1 = 1'b1; rdb2 = 1'b1;
    checks++; if (ifa.DO1 !== 9'h1AA) begin errors++; $display("FAIL coll_do1_a: got %h want 1aa", ifa.DO1); end
    checks++; if (ifa.DO2 !== 9'h1AA) begin errors++; $display("FAIL coll_do2_a: got %h want 1aa", ifa.DO2); end
    tick();
    checks++; if (ifb.DO1 !== 9'h055) begin errors++; $display("FAIL coll_do1_b: got %h want 055", ifb.DO1); end
    checks++; if (ifb.DO2 !== 9'h055) begin errors++; $display("FAIL coll_do2_b: got %h want 055", ifb.DO2); end
    do_read(8'd10, 8'd10);
    checks++; if (ifa.DO1 !== 9'h1AA) begin errors++; $display("FAIL coll_after_a: got %h want 1aa", ifa.DO1); end
    checks++; if (ifb.DO2 !== 9'h1AA) begin errors++; $display("FAIL coll_after_b: got %h want 1aa", ifb.DO2); end
  endtask

  task automatic test_hold_range();
    do_write(8'd220, 9'h123);   // valid in dut_a, dropped in dut_b
    do_read(8'd220, 8'd220);
    checks++; if (ifa.DO1 !== 9'h123) begin errors++; $display("FAIL range_do1_a: got %h want 123", ifa.DO1); end
    checks++; if (ifb.DO1 !== 9'h000) begin errors++; $display("FAIL range_do1_b: got %h want 000", ifb.DO1); end
    checks++; if (ifb.DO2 !== 9'h000) begin errors++; $display("FAIL range_do2_b: got %h want 000", ifb.DO2); end
    do_write(8'd5, 9'h0C3);
    do_read(8'd5, 8'd5);
    for (int i = 0; i < 10; i++) begin
      raddr1 = 8'(i * 7); rdb1 = 1'b1;
      waddr = 8'd5; din = 9'h111; wrb = (i == 0) ? 1'b0 : 1'b1;
      tick();
      checks++; if (ifa.DO1 !== 9'h0C3) begin errors++; $display("FAIL hold_a[%0d]: got %h want 0c3", i, ifa.DO1); end
      checks++; if (ifb.DO1 !== 9'h0C3) begin errors++; $display("FAIL hold_b[%0d]: got %h want 0c3", i, ifb.DO1); end
    end
    wrb = 1'b1;
    do_read(8'd5, 8'd5);
    checks++; if (ifa.DO1 !== 9'h111) begin errors++; $display("FAIL hold_new_a: got %h want 111", ifa.DO1); end
  endtask

`ifdef PSEVDO_RAM_PARITY_EN
  task automatic test_parity();
    do_write(8'd7, 9'h0F0);
    dut_a.mem[7][0] = ~dut_a.mem[7][0];
    dut_b.mem[7][0] = ~dut_b.mem[7][0];
    raddr1 = 8'd10; raddr2 = 8'd7; rdb1 = 1'b0; rdb2 = 1'b0;
    tick();
    rdb1 = 1'b1; rdb2 = 1'b1;
    checks++; if (ifa.DO2 !== 9'h0F1) begin errors++; $display("FAIL par_do2_a: got %h want 0f1", ifa.DO2); end
    checks++; if (ifa.PERR2 !== 1'b1) begin errors++; $display("FAIL par_perr2_a: got %b want 1", ifa.PERR2); end
    checks++; if (ifa.PERR1 !== 1'b0) begin errors++; $display("FAIL par_perr1_a: got %b want 0", ifa.PERR1); end
    tick();
    checks++; if (ifb.DO2 !== 9'h0F1) begin errors++; $display("FAIL par_do2_b: got %h want 0f1", ifb.DO2); end
    checks++; if (ifb.PERR2 !== 1'b1) begin errors++; $display("FAIL par_perr2_b: got %b want 1", ifb.PERR2); end
    do_read(8'd10, 8'd10);
    checks++; if (ifa.PERR2 !== 1'b0) begin errors++; $display("FAIL par_clean_a: got %b want 0", ifa.PERR2); end
    checks++; if (ifb.PERR2 !== 1'b0) begin errors++; $display("FAIL par_clean_b: got %b want 0", ifb.PERR2); end
    checks++; if (ifb.DO2 !== 9'h1AA) begin errors++; $display("FAIL par_clean_do2_b: got %h want 1aa", ifb.DO2); end
  endtask
`endif

  task automatic test_reset_mid();
    raddr1 = 8'd3; raddr2 = 8'd3; rdb1 = 1'b0; rdb2 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (ifa.DO1 !== 9'h1A5) begin errors++; $display("FAIL mid_pre_a: got %h want 1a5", ifa.DO1); end
    checks++; if (ifb.DO1 !== 9'h1A5) begin errors++; $display("FAIL mid_pre_b: got %h want 1a5", ifb.DO1); end
    rst = 1'b1; waddr = 8'd3; din = 9'h155; wrb = 1'b0;
    tick();
    wrb = 1'b1;
    checks++; if (ifa.READY !== 1'b0) begin errors++; $display("FAIL mid_ready_a: got %b want 0", ifa.READY); end
    checks++; if (ifa.DO1 !== 9'h000) begin errors++; $display("FAIL mid_do1_a: got %h want 000", ifa.DO1); end
    checks++; if (ifb.READY !== 1'b0) begin errors++; $display("FAIL mid_ready_b: got %b want 0", ifb.READY); end
    checks++; if (ifb.DO2 !== 9'h000) begin errors++; $display("FAIL mid_do2_b: got %h want 000", ifb.DO2); end
    rst = 1'b0;
    for (int i = 0; i < 128; i++) tick();
    checks++; if (ifa.READY !== 1'b0) begin errors++; $display("FAIL half_ready_a: got %b want 0", ifa.READY); end
    checks++; if (ifb.READY !== 1'b0) begin errors++; $display("FAIL half_ready_b: got %b want 0", ifb.READY); end
    checks++; if (ifa.DO1 !== 9'h000) begin errors++; $display("FAIL half_do1_a: got %h want 000", ifa.DO1); end
    rst = 1'b1;
    tick();
    rdb1 = 1'b1; rdb2 = 1'b1;
    wait_sweep("midrst");
    do_read(8'd3, 8'd10);
    checks++; if (ifa.DO1 !== 9'h000) begin errors++; $display("FAIL wipe_do1_a: got %h want 000", ifa.DO1); end
    checks++; if (ifa.DO2 !== 9'h000) begin errors++; $display("FAIL wipe_do2_a: got %h want 000", ifa.DO2); end
    checks++; if (ifb.DO1 !== 9'h000) begin errors++; $display("FAIL wipe_do1_b: got %h want 000", ifb.DO1); end
    checks++; if (ifb.DO2 !== 9'h000) begin errors++; $display("FAIL wipe_do2_b: got %h want 000", ifb.DO2); end
    do_read(8'd200, 8'd220);
    checks++; if (ifa.DO1 !== 9'h000) begin errors++; $display("FAIL wipe_200_a: got %h want 000", ifa.DO1); end
    checks++; if (ifa.DO2 !== 9'h000) begin errors++; $display("FAIL wipe_220_a: got %h want 000", ifa.DO2); end
  endtask

  initial begin
    test_reset();
    test_clear_reads();
    test_dual_port();
    test_collision();
    test_hold_range();
`ifdef PSEVDO_RAM_PARITY_EN
    test_parity();
`endif
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psevdo_ram_2r1w.md
# psevdo_ram_2r1w

Parametrised single-clock RAM with one write port and two independent read ports, each with its own registered read path. After reset it runs a hardware clear sweep that zeroes the array and holds READY low until the sweep completes. It also has configurable read latency and a selectable read-during-write policy. It is the next-generation storage primitive for the pseudo-RAM datapath, replacing the fixed 9x256 block whose second output is tied to zero.

## Interface
- DW, 9, data word width (1..32)
- AW, 8, address width
- DEPTH, 256, implemented words (2 <= DEPTH <= 2**AW)
- RD_PIPE, 0, extra output register stage per read port (0 or 1)
- WRITE_FIRST, 1, read/write same-address policy: 1 = new data, 0 = old data

- CLKS  in  1  single clock, all logic on posedge
- RST  in  1  reset; synchronous and active-high
- DIn  in  DW  write data
- WADDR  in  AW  write address
- WRB  in  1  write enable, active-low
- RADDR1 / RADDR2  in  AW  read addresses, ports 1/2
- RDB1 / RDB2  in  1  read enables, active-low
- DO1 / DO2  out  DW  registered read data
- READY  out  1  high when clear sweep is done and ports are accepted
- PERR1 / PERR2  out  1  parity error aligned with DO1/DO2; present only with PSEVDO_RAM_PARITY_EN

## Operation
- FSM has two states: ST_CLEAR and ST_RUN. RST=1 forces ST_CLEAR with clear address 0 on the next edge.
- ST_CLEAR, entered with RST=0:
  - Writes 0 to clear address c each cycle, c = 0..DEPTH-1.
  - After writing DEPTH-1, moves to ST_RUN.
  - WRB, RDB1 and RDB2 are ignored; DO1, DO2 and PERRx hold 0.
- ST_RUN accepts the following:
  - WRB=0 writes DIn to mem[WADDR].
  - RDBx=0 loads the stage-1 register of port x with mem[RADDRx].
  - RDBx=1 holds stage 1, so DOx keeps its last value.
- Ports are fully independent:
  - Both read ports may address the same word in the same cycle.
  - Each read port may hit the write address in the same cycle.
- Collision (RDBx=0, WRB=0, RADDRx==WADDR):
  - WRITE_FIRST=1: DOx returns DIn.
  - WRITE_FIRST=0: DOx returns the prior contents.
- Out-of-range addresses (address >= DEPTH):
  - Writes are dropped.
  - Reads return 0, and PERRx is 0.
- Reset mid-operation:
  - Any in-flight read data is discarded.
  - A new full sweep starts.
  - Writes from the cycle RST is sampled high are dropped.

## Timing
- Reset values: DO1=DO2=0, READY=0, PERR1=PERR2=0, FSM=ST_CLEAR, clear address 0.
- The clear sweep takes exactly DEPTH cycles after RST deasserts. READY rises on the edge that ends the write of address DEPTH-1.
- READY is registered and changes only on a clock edge.
- Read latency is 1+RD_PIPE edges from the edge sampling RDBx=0.
- With RD_PIPE=1, stage 2 copies stage 1 every cycle, so held data stays held.
- Write latency: a write sampled at edge n is visible to a read sampled at edge n+1, or at edge n itself under WRITE_FIRST=1.
- Throughput: one write plus two reads per cycle, with no stalls in ST_RUN.

## Configuration
- PSEVDO_RAM_PARITY_EN defined:
  - The array is DW+1 bits wide, storing even parity of the write data (the clear sweep stores a zero word with parity 0).
  - Each read recomputes parity; a mismatch drives PERRx=1.
  - PERRx is registered and pipelined identically to DOx, so it is valid for that read result only and is not sticky.
  - A WRITE_FIRST bypass uses the parity of DIn, so PERRx=0.
- PSEVDO_RAM_PARITY_EN undefined:
  - The array is DW wide and the PERR1/PERR2 ports do not exist.
  - Behaviour is otherwise identical.

## Structure
- Package psevdo_ram_pkg holds:
  - the state typedef (ST_CLEAR, ST_RUN);
  - an even-parity function;
  - default localparams for DW, AW and DEPTH.
- Sub-module psevdo_ram_rdport contains one read port: address range check, collision bypass, stage-1/stage-2 registers and optional parity check. It is instantiated twice.
- The top level owns the array, the write port and the clear FSM.

## Test plan
- Reset, clear and read: pulse RST for 3 cycles with defaults, then read addresses 0, 128 and 255 on both ports -> READY rises exactly 256 cycles after RST falls, and all reads return 9'h000.
- Dual-port independence: write 0x1A5 to addr 3 and 0x07E to addr 200, then read 3 on port 1 and 200 on port 2 in the same cycle -> DO1=0x1A5 and DO2=0x07E one cycle later (two cycles with RD_PIPE=1).
- Collision policy: mem[10]=0x055, then write 0x1AA to addr 10 while both ports read 10 -> DO1=DO2=0x1AA with WRITE_FIRST=1, 0x055 with WRITE_FIRST=0.
- Hold and range: DEPTH=200; write 0x123 to addr 220, then read 220 -> DOx=0. Read 5 and then drive RDB1=1 for 10 cycles -> DO1 stays at mem[5].
- Reset mid-operation: assert RST halfway through the sweep and again during streaming reads -> READY=0 and DOx=0 on the next edge, then a full 256-cycle sweep, and the previously written data reads back as 0.
- Parity (macro defined): write 0x0F0 to addr 7, then backdoor-flip bit 0 of mem[7] and read port 2 -> DO2=0x0F1 and PERR2=1 for that result only. An uncorrupted read gives PERR2=0.
